// File: rtl/chip8_pkg.sv
// Shared constants for the CHIP-8 timer bank and anything else that runs off the 60 Hz tick.
package chip8_pkg;

  localparam int CHIP8_TICK_HZ = 60;

  localparam int TIMER_DELAY = 0;
  localparam int TIMER_SOUND = 1;

  // Only the sound timer drives the buzzer in a stock CHIP-8 machine.
  localparam logic [1:0] CHIP8_SOUND_MASK = 2'b10;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chip8_tick_div.sv
// Free-running clock divider producing a one-cycle tick every CLK_HZ/TICK_HZ cycles.
module chip8_tick_div #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("chip8_tick_div: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [CW-1:0] div_cnt;

  // Count holds while paused so the period resumes where it left off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!pause) begin
      if (div_cnt == LAST) div_cnt <= '0;
      else                 div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == LAST) && !pause;

endmodule

// File: rtl/chip8_timers.sv
// Bank of CHIP-8 down-counters (delay, sound, extras) sharing one tick divider.
module chip8_timers import chip8_pkg::*; #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = CHIP8_TICK_HZ,
  parameter int NUM_TIMERS = 2,
  parameter int WIDTH      = 8,
  parameter logic [NUM_TIMERS-1:0] SOUND_MASK = NUM_TIMERS'(CHIP8_SOUND_MASK),
  localparam int SELW = sel_width(NUM_TIMERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause,
  input  logic                  wr_en,
  input  logic [SELW-1:0]       wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [SELW-1:0]       rd_sel,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  tick,
  output logic [NUM_TIMERS-1:0] active,
  output logic [NUM_TIMERS-1:0] expired,
  output logic                  buzzer
);

  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  function automatic logic hits_zero(input logic [WIDTH-1:0] v);
    return v == WIDTH'(1);
  endfunction

  logic [WIDTH-1:0] cnt_w [NUM_TIMERS];

  chip8_tick_div #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .pause (pause),
    .tick  (tick)
  );

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    logic             load;
    logic [WIDTH-1:0] cnt_p1;
    logic             expired_p1;

    assign load = wr_en && (wr_sel == SELW'(i));

    // A load on the tick edge overrides the decrement and suppresses expiry.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_p1     <= '0;
        expired_p1 <= 1'b0;
      end else begin
        expired_p1 <= 1'b0;
        if (load) begin
          cnt_p1 <= wr_data;
        end else if (tick) begin
          cnt_p1     <= sat_dec(cnt_p1);
          expired_p1 <= hits_zero(cnt_p1);
        end
      end
    end

    assign cnt_w[i]   = cnt_p1;
    assign active[i]  = |cnt_p1;
    assign expired[i] = expired_p1;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (rd_sel == SELW'(i)) rd_data = cnt_w[i];
    end
  end

  assign buzzer = |(active & SOUND_MASK);

endmodule

// File: tb/tb_chip8_timers.sv
// Scoreboard bench for chip8_timers at DIV=10 with a delay and a sound channel.
module tb_chip8_timers;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pause = 1'b0;
  logic       wr_en = 1'b0;
  logic [0:0] wr_sel = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic [0:0] rd_sel = 1'b0;
  logic [7:0] rd_data;
  logic       tick;
  logic [1:0] active;
  logic [1:0] expired;
  logic       buzzer;

  chip8_timers #(
    .CLK_HZ     (600),
    .TICK_HZ    (60),
    .NUM_TIMERS (2),
    .WIDTH      (8),
    .SOUND_MASK (2'b10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pause   (pause),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .tick    (tick),
    .active  (active),
    .expired (expired),
    .buzzer  (buzzer)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    v;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int v);
    sbq.push_back('{tag, v});
  endtask

  task automatic pop(input string tag, input logic [31:0] obs);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_unexpected"}, obs, 32'hFFFF_FFFF);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, obs, 32'(e.v));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int v);
    wr_en   = 1'b1;
    wr_sel  = 1'(ch);
    wr_data = 8'(v);
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic obs_ch(input string tag, input int ch);
    rd_sel = 1'(ch);
    #1;
    pop(tag, 32'(rd_data));
    rd_sel = 1'b0;
  endtask

  task automatic wait_tick();
    int i = 0;
    while (!tick && i < 12) begin
      step(1);
      i++;
    end
    chk("wait_tick", 32'(tick), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    int n;

    // reset state
    step(3);
    push("rst_rd", 0); push("rst_active", 0); push("rst_expired", 0);
    push("rst_buzzer", 0); push("rst_tick", 0);
    pop("rst_rd", 32'(rd_data)); pop("rst_active", 32'(active));
    pop("rst_expired", 32'(expired)); pop("rst_buzzer", 32'(buzzer));
    pop("rst_tick", 32'(tick));

    // first tick on the 10th edge after release, then every 10
    rst = 1'b1;
    step(8);
    push("tick_pre", 0);    pop("tick_pre", 32'(tick));
    step(1);
    push("tick_first", 1);  pop("tick_first", 32'(tick));
    step(5);
    push("tick_mid", 0);    pop("tick_mid", 32'(tick));
    step(5);
    push("tick_second", 1); pop("tick_second", 32'(tick));

    // countdown of ch0 from 3
    step(1);
    load(0, 3);
    push("ld3_rd", 3); push("ld3_active", 1); push("ld3_buzzer", 0);
    obs_ch("ld3_rd", 0); pop("ld3_active", 32'(active)); pop("ld3_buzzer", 32'(buzzer));
    for (int k = 2; k >= 0; k--) begin
      wait_tick();
      step(1);
      push("cd_rd", k);                    obs_ch("cd_rd", 0);
      push("cd_expired", (k == 0) ? 1 : 0); pop("cd_expired", 32'(expired));
    end
    push("cd_active", 0);    pop("cd_active", 32'(active));
    step(1);
    push("cd_exp_after", 0); pop("cd_exp_after", 32'(expired));

    // sound channel drives buzzer, delay channel does not
    load(1, 5);
    load(0, 9);
    push("bz_on", 1); push("bz_active", 3);
    pop("bz_on", 32'(buzzer)); pop("bz_active", 32'(active));
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      step(1);
      push("bz_buzzer", (k < 5) ? 1 : 0); pop("bz_buzzer", 32'(buzzer));
      push("bz_ch0", 9 - k);              obs_ch("bz_ch0", 0);
      push("bz_ch1", 5 - k);              obs_ch("bz_ch1", 1);
    end
    push("bz_expired", 2); push("bz_active_end", 1);
    pop("bz_expired", 32'(expired)); pop("bz_active_end", 32'(active));
    wait_tick();
    step(1);
    push("bz_ch0_only", 3); push("bz_off", 0);
    obs_ch("bz_ch0_only", 0); pop("bz_off", 32'(buzzer));

    // load on the tick edge wins over the decrement
    load(0, 7);
    load(1, 2);
    wait_tick();
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'd4;
    step(1);
    wr_en = 1'b0;
    push("col_ch0", 4); push("col_ch1", 1); push("col_expired", 0);
    obs_ch("col_ch0", 0); obs_ch("col_ch1", 1); pop("col_expired", 32'(expired));
    wait_tick();
    step(1);
    push("col2_ch0", 3); push("col2_ch1", 0); push("col2_expired", 2);
    obs_ch("col2_ch0", 0); obs_ch("col2_ch1", 1); pop("col2_expired", 32'(expired));

    // loading zero onto an active channel clears without expiry
    load(0, 0);
    push("ld0_rd", 0); push("ld0_active", 0); push("ld0_expired", 0);
    obs_ch("ld0_rd", 0); pop("ld0_active", 32'(active)); pop("ld0_expired", 32'(expired));
    step(1);
    push("ld0_exp_after", 0); pop("ld0_exp_after", 32'(expired));

    // pause mid-period freezes divider and counters
    wait_tick();
    step(1);
    load(0, 6);
    step(4);
    pause = 1'b1;
    nt = 0;
    for (int c = 0; c < 25; c++) begin
      step(1);
      if (tick) nt++;
    end
    push("pause_ticks", 0); pop("pause_ticks", 32'(nt));
    push("pause_ch0", 6);   obs_ch("pause_ch0", 0);
    pause = 1'b0;
    n = 0;
    while (!tick && n < 20) begin
      step(1);
      n++;
    end
    push("pause_remain", 4); pop("pause_remain", 32'(n));
    step(1);
    push("pause_dec", 5);    obs_ch("pause_dec", 0);

    // asynchronous reset just before a terminal decrement
    load(0, 2);
    wait_tick();
    step(1);
    wait_tick();
    #2;
    rst = 1'b0;
    #1;
    push("arst_ch0", 0); push("arst_active", 0); push("arst_expired", 0); push("arst_tick", 0);
    obs_ch("arst_ch0", 0); pop("arst_active", 32'(active));
    pop("arst_expired", 32'(expired)); pop("arst_tick", 32'(tick));
    step(2);
    push("arst_exp_hold", 0); pop("arst_exp_hold", 32'(expired));
    rst = 1'b1;
    step(1);
    push("arst_exp_rel", 0); push("arst_rd_rel", 0);
    pop("arst_exp_rel", 32'(expired)); obs_ch("arst_rd_rel", 0);

    chk("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chip8_timers.md
# chip8_timers

Parametrised bank of CHIP-8 down-counting timers: the delay timer, the sound timer, and optional extra channels. All channels decrement together at a fixed tick rate derived from the system clock. The block sits beside `cpu`, which loads channels through a write port (FX15/FX18) and reads them back (FX07). A buzzer output is driven while any sound-capable channel is nonzero.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 60, decrement rate.
- `NUM_TIMERS`, 2, channel count (≥1).
- `WIDTH`, 8, counter width per channel.
- `SOUND_MASK`, 'b10, NUM_TIMERS-bit mask of channels that drive `buzzer`.

Ports (`SELW` = max(1, $clog2(NUM_TIMERS))):
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pause`  in  1  high freezes divider and all counters.
- `wr_en`  in  1  load strobe.
- `wr_sel`  in  SELW  channel to load.
- `wr_data`  in  WIDTH  load value.
- `rd_sel`  in  SELW  channel to read.
- `rd_data`  out  WIDTH  current value of channel `rd_sel`.
- `tick`  out  1  one-cycle pulse at TICK_HZ.
- `active`  out  NUM_TIMERS  per-channel value ≠ 0.
- `expired`  out  NUM_TIMERS  one-cycle pulse when a channel reaches 0 by decrement.
- `buzzer`  out  1  |(active & SOUND_MASK).

## Operation
- Divider: DIV = CLK_HZ / TICK_HZ (integer; remainder error accepted). Elaboration error if DIV < 2. `div_cnt` counts 0..DIV-1 and wraps to 0.
- `tick` = (div_cnt == DIV-1) && !pause.
- On each `tick` edge, every nonzero channel decrements by 1. Zero channels stay at 0; decrement saturates and never wraps.
- Load: when `wr_en` is high, channel `wr_sel` takes `wr_data` at the edge. A `wr_sel` value ≥ NUM_TIMERS is ignored.
- Load and tick on the same channel at the same edge: the load wins. That channel does not decrement and does not pulse `expired`. Other channels decrement normally.
- Load of 0 onto an active channel: the channel clears and `expired` does not pulse.
- `expired[i]` is registered. It goes high for exactly one cycle after the edge where channel i went 1→0 by decrement.
- `pause` high: `div_cnt` and all counters hold, and no tick occurs. Loads still take effect. On release, the divider resumes from its held count.
- `rd_select` ≥ NUM_TIMERS returns 0.

## Timing
- Reset value of every output is 0. All counters, `div_cnt` and the `expired` register clear asynchronously while `rst` is low, including mid-countdown; no `expired` pulse results from a reset.
- The first tick after reset release is in the cycle where div_cnt = DIV-1, i.e. the DIV-th rising edge after release.
- Load latency is 1 edge: the value is visible on `rd_data` and `active` after the load edge.
- `rd_data`, `active`, `buzzer` and `tick` are combinational from registers, with no extra latency.
- `expired` lags the terminal decrement by one cycle.
- Tick period is exactly DIV cycles when `pause` is low.

## Structure
- Package `chip8_pkg`:
  - `CHIP8_TICK_HZ` = 60.
  - Channel indices `TIMER_DELAY` = 0 and `TIMER_SOUND` = 1.
  - Default `SOUND_MASK`.
- Sub-module `chip8_tick_div`: the divider, with parameters CLK_HZ and TICK_HZ, inputs clk, rst and pause, and output tick. Reusable for the display refresh.
- Channel registers: a generate loop over NUM_TIMERS.

## Test plan
The bench uses CLK_HZ=600 and TICK_HZ=60, giving DIV=10, with NUM_TIMERS=2 and SOUND_MASK='b10.
- Reset release → all outputs 0; first `tick` at the 10th edge after release, then every 10 cycles.
- Load ch0=3 → `active[0]`=1 and `rd_data`=3. Value reads 2, 1, 0 after successive ticks. `expired[0]` pulses one cycle after the third tick, then `active[0]`=0.
- Load ch1=5 and ch0=9 → `buzzer` high for 5 ticks, then low while ch0 is still 4. Ch0 alone never raises `buzzer`.
- Ch0=7, load ch0=4 on the tick edge → reads 4, not 6. Ch1=2 decrements to 1 on the same edge.
- `pause` high for 25 cycles mid-period → no `tick`, values frozen. The next tick arrives after the remaining divider count.
- `rst` low between edges while ch0=2 → ch0 reads 0 immediately, and `expired` stays 0.
